// File: rtl/serial_add_sub_pkg.sv
// serial_add_pkg: shared definitions for the serial add/subtract unit.
//   - state_t   : FSM state encoding (IDLE / RUN / DONE)
//   - cnt_width : width of the digit counter, clog2(WIDTH/DIGIT) with a floor of 1
package serial_add_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // A single-digit operation (N = 1) still needs a 1-bit counter.
    function automatic int cnt_width(input int width, input int digit);
        int n;
        n = width / digit;
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/serial_add_sub_if.sv
// serial_add_sub_if: request/result bundle for serial_add_sub.
//   master : drives start, sub, a, b; observes busy, done, sum, cout, ovf
//   slave  : the arithmetic unit side
interface serial_add_sub_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic             sub;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    modport master (
        output start, sub, a, b,
        input  busy, done, sum, cout, ovf
    );

    modport slave (
        input  start, sub, a, b,
        output busy, done, sum, cout, ovf
    );
endinterface

// File: rtl/serial_add_sub_fa_cell.sv
// fa_cell: gate-level one-bit full adder.
//   a, b, ci : addend bits and carry in
//   s, co    : sum bit and carry out
module fa_cell (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);
    logic w_p;
    logic w_g;
    logic w_t;

    xor g_p  (w_p, a, b);
    xor g_s  (s, w_p, ci);
    and g_g  (w_g, a, b);
    and g_t  (w_t, w_p, ci);
    or  g_co (co, w_g, w_t);
endmodule

// File: rtl/serial_add_sub.sv
// serial_add_sub: multi-cycle add/subtract, DIGIT bits per clock, LSB first.
//   clk   : clock, rising edge
//   rst_n : synchronous active-low reset
//   bus   : serial_add_sub_if.slave
//             start/sub/a/b in; busy/done/sum/cout/ovf out
// Parameters: WIDTH (>= 2, multiple of DIGIT), DIGIT (1..WIDTH).
// Optional: define SERIAL_ADD_SAT_EN to saturate sum on signed overflow.
module serial_add_sub
    import serial_add_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    serial_add_sub_if.slave    bus
);
    localparam int                N     = WIDTH / DIGIT;
    localparam int                CNT_W = cnt_width(WIDTH, DIGIT);
    localparam logic [CNT_W-1:0]  LAST  = CNT_W'(N - 1);

    state_t           r_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_res;
    logic [WIDTH-1:0] r_sum;
    logic [CNT_W-1:0] r_cnt;
    logic             r_carry;
    logic             r_cout;
    logic             r_ovf;
    logic             r_busy;
    logic             r_done;

    logic [DIGIT-1:0] w_s;
    logic [DIGIT:0]   w_c;
    logic [WIDTH-1:0] w_res_next;
    logic [WIDTH-1:0] w_sum_next;
    logic             w_ovf;

    // Ripple chain of full adders for one digit.
    assign w_c[0] = r_carry;
    generate
        for (genvar i = 0; i < DIGIT; i++) begin : g_fa
            fa_cell u_fa (
                .a  (r_a[i]),
                .b  (r_b[i]),
                .ci (w_c[i]),
                .s  (w_s[i]),
                .co (w_c[i+1])
            );
        end

        // New digit enters at the top; after N digits the LSB digit sits at bit 0.
        if (DIGIT == WIDTH) begin : g_res_one
            assign w_res_next = w_s;
        end else begin : g_res_shift
            assign w_res_next = {w_s, r_res[WIDTH-1:DIGIT]};
        end
    endgenerate

    // Only meaningful on the last digit, where bit DIGIT-1 is the result MSB.
    assign w_ovf = w_c[DIGIT-1] ^ w_c[DIGIT];

`ifdef SERIAL_ADD_SAT_EN
    localparam logic [WIDTH-1:0] SAT_POS = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] SAT_NEG = {1'b1, {(WIDTH-1){1'b0}}};
    // On overflow the carry out tells the direction: set means both operands negative.
    assign w_sum_next = w_ovf ? (w_c[DIGIT] ? SAT_NEG : SAT_POS) : w_res_next;
`else
    assign w_sum_next = w_res_next;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_res   <= '0;
            r_sum   <= '0;
            r_cnt   <= '0;
            r_carry <= 1'b0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                IDLE, DONE: begin
                    r_done <= 1'b0;
                    if (bus.start) begin
                        // Subtract as a + ~b + 1: the +1 enters as the initial carry.
                        r_a     <= bus.a;
                        r_b     <= bus.sub ? ~bus.b : bus.b;
                        r_carry <= bus.sub;
                        r_cnt   <= '0;
                        r_res   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= RUN;
                    end else begin
                        r_state <= IDLE;
                    end
                end
                RUN: begin
                    r_a     <= r_a >> DIGIT;
                    r_b     <= r_b >> DIGIT;
                    r_res   <= w_res_next;
                    r_carry <= w_c[DIGIT];
                    r_cnt   <= r_cnt + 1'b1;
                    if (r_cnt == LAST) begin
                        r_sum   <= w_sum_next;
                        r_cout  <= w_c[DIGIT];
                        r_ovf   <= w_ovf;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= DONE;
                    end
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign bus.busy = r_busy;
    assign bus.done = r_done;
    assign bus.sum  = r_sum;
    assign bus.cout = r_cout;
    assign bus.ovf  = r_ovf;
endmodule

// File: tb/tb_serial_add_sub.sv
// tb_serial_add_sub: directed checks of serial_add_sub at DIGIT = 1, 4 and 8 (WIDTH = 8).
module tb_serial_add_sub;
    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    serial_add_sub_if #(.WIDTH(8)) if1 ();
    serial_add_sub_if #(.WIDTH(8)) if4 ();
    serial_add_sub_if #(.WIDTH(8)) if8 ();

    serial_add_sub #(.WIDTH(8), .DIGIT(1)) u_d1 (.clk(clk), .rst_n(rst_n), .bus(if1));
    serial_add_sub #(.WIDTH(8), .DIGIT(4)) u_d4 (.clk(clk), .rst_n(rst_n), .bus(if4));
    serial_add_sub #(.WIDTH(8), .DIGIT(8)) u_d8 (.clk(clk), .rst_n(rst_n), .bus(if8));

`ifdef SERIAL_ADD_SAT_EN
    localparam logic [7:0] EXP_D4_SUM = 8'h80;
    localparam logic [7:0] EXP_D8_SUM = 8'h7F;
`else
    localparam logic [7:0] EXP_D4_SUM = 8'h7F;
    localparam logic [7:0] EXP_D8_SUM = 8'h80;
`endif

    // Present a request to the DIGIT=1 unit for one edge; returns #1 after that edge.
    task automatic start1(input logic [7:0] a, input logic [7:0] b, input logic sub);
        if1.a = a; if1.b = b; if1.sub = sub; if1.start = 1'b1;
        @(posedge clk); #1;
        if1.start = 1'b0;
    endtask

    // Step until done on the DIGIT=1 unit; idx = samples since start edge, -1 on timeout.
    task automatic wait_done1(output int idx, output int busy_cnt);
        idx = -1;
        busy_cnt = 0;
        for (int i = 0; i < 30; i++) begin
            if (if1.done) begin
                idx = i;
                return;
            end
            if (if1.busy) busy_cnt++;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (if1.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", if1.busy); end
        checks++; if (if1.done !== 1'b0) begin errors++; $display("FAIL reset_done got %b exp 0", if1.done); end
        checks++; if (if1.sum !== 8'h00) begin errors++; $display("FAIL reset_sum got %h exp 00", if1.sum); end
        checks++; if (if1.cout !== 1'b0) begin errors++; $display("FAIL reset_cout got %b exp 0", if1.cout); end
        checks++; if (if1.ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf got %b exp 0", if1.ovf); end
        checks++; if (if4.sum !== 8'h00 || if8.sum !== 8'h00) begin errors++; $display("FAIL reset_sum_d4d8 got %h/%h exp 00/00", if4.sum, if8.sum); end
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_add_basic;
        int idx, bc, extra;
        start1(8'h5A, 8'h33, 1'b0);
        wait_done1(idx, bc);
        checks++; if (idx !== 8) begin errors++; $display("FAIL add_latency got %0d exp 8", idx); end
        checks++; if (bc !== 8) begin errors++; $display("FAIL add_busy_cycles got %0d exp 8", bc); end
        checks++; if (if1.sum !== 8'h8D) begin errors++; $display("FAIL add_sum got %h exp 8d", if1.sum); end
        checks++; if (if1.cout !== 1'b0) begin errors++; $display("FAIL add_cout got %b exp 0", if1.cout); end
        checks++; if (if1.ovf !== 1'b1) begin errors++; $display("FAIL add_ovf got %b exp 1", if1.ovf); end
        extra = 0;
        repeat (4) begin
            @(posedge clk); #1;
            if (if1.done) extra++;
        end
        checks++; if (extra !== 0) begin errors++; $display("FAIL add_single_done got %0d extra pulses exp 0", extra); end
        checks++; if (if1.sum !== 8'h8D || if1.busy !== 1'b0) begin errors++; $display("FAIL add_hold got sum %h busy %b exp 8d 0", if1.sum, if1.busy); end
    endtask

    task automatic test_back_to_back;
        int idx, bc;
        start1(8'hFF, 8'h01, 1'b0);
        wait_done1(idx, bc);
        checks++; if (idx !== 8) begin errors++; $display("FAIL b2b_first_latency got %0d exp 8", idx); end
        checks++; if (if1.sum !== 8'h00 || if1.cout !== 1'b1 || if1.ovf !== 1'b0) begin
            errors++; $display("FAIL b2b_first got sum %h cout %b ovf %b exp 00 1 0", if1.sum, if1.cout, if1.ovf); end
        // Still in DONE: start here must be taken with no idle cycle.
        start1(8'h10, 8'h20, 1'b1);
        checks++; if (if1.busy !== 1'b1 || if1.done !== 1'b0) begin
            errors++; $display("FAIL b2b_no_bubble got busy %b done %b exp 1 0", if1.busy, if1.done); end
        wait_done1(idx, bc);
        checks++; if (idx !== 8 || bc !== 8) begin errors++; $display("FAIL b2b_second_timing got idx %0d busy %0d exp 8 8", idx, bc); end
        checks++; if (if1.sum !== 8'hF0) begin errors++; $display("FAIL b2b_sub_sum got %h exp f0", if1.sum); end
        checks++; if (if1.cout !== 1'b0 || if1.ovf !== 1'b0) begin
            errors++; $display("FAIL b2b_sub_flags got cout %b ovf %b exp 0 0", if1.cout, if1.ovf); end
        @(posedge clk); #1;
    endtask

    task automatic test_start_ignored;
        int idx, bc;
        start1(8'h01, 8'h02, 1'b0);
        repeat (2) begin @(posedge clk); #1; end
        if1.a = 8'h7F; if1.b = 8'h7F; if1.start = 1'b1;
        @(posedge clk); #1;
        if1.start = 1'b0;
        wait_done1(idx, bc);
        checks++; if (idx < 0) begin errors++; $display("FAIL ign_timeout got no done exp done"); end
        checks++; if (if1.sum !== 8'h03 || if1.ovf !== 1'b0 || if1.cout !== 1'b0) begin
            errors++; $display("FAIL ign_result got sum %h cout %b ovf %b exp 03 0 0", if1.sum, if1.cout, if1.ovf); end
        @(posedge clk); #1;
        checks++; if (if1.busy !== 1'b0) begin errors++; $display("FAIL ign_no_rerun got busy %b exp 0", if1.busy); end
    endtask

    task automatic test_reset_mid_run;
        int idx, bc, dn;
        start1(8'h5A, 8'h33, 1'b0);
        repeat (3) begin @(posedge clk); #1; end
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        checks++; if (if1.busy !== 1'b0 || if1.done !== 1'b0 || if1.sum !== 8'h00) begin
            errors++; $display("FAIL midrst_state got busy %b done %b sum %h exp 0 0 00", if1.busy, if1.done, if1.sum); end
        dn = 0;
        repeat (12) begin
            @(posedge clk); #1;
            if (if1.done) dn++;
        end
        checks++; if (dn !== 0) begin errors++; $display("FAIL midrst_no_done got %0d pulses exp 0", dn); end
        start1(8'h0A, 8'h05, 1'b0);
        wait_done1(idx, bc);
        checks++; if (idx !== 8 || if1.sum !== 8'h0F) begin
            errors++; $display("FAIL midrst_after got idx %0d sum %h exp 8 0f", idx, if1.sum); end
        @(posedge clk); #1;
    endtask

    task automatic test_digit4;
        int idx;
        if4.a = 8'h80; if4.b = 8'h01; if4.sub = 1'b1; if4.start = 1'b1;
        @(posedge clk); #1;
        if4.start = 1'b0;
        idx = -1;
        for (int i = 0; i < 10; i++) begin
            if (if4.done) begin idx = i; break; end
            @(posedge clk); #1;
        end
        checks++; if (idx !== 2) begin errors++; $display("FAIL d4_latency got %0d exp 2", idx); end
        checks++; if (if4.sum !== EXP_D4_SUM) begin errors++; $display("FAIL d4_sum got %h exp %h", if4.sum, EXP_D4_SUM); end
        checks++; if (if4.cout !== 1'b1 || if4.ovf !== 1'b1) begin
            errors++; $display("FAIL d4_flags got cout %b ovf %b exp 1 1", if4.cout, if4.ovf); end
        @(posedge clk); #1;
    endtask

    task automatic test_digit8;
        int idx;
        if8.a = 8'h40; if8.b = 8'h40; if8.sub = 1'b0; if8.start = 1'b1;
        @(posedge clk); #1;
        if8.start = 1'b0;
        checks++; if (if8.busy !== 1'b1) begin errors++; $display("FAIL d8_busy got %b exp 1", if8.busy); end
        idx = -1;
        for (int i = 0; i < 10; i++) begin
            if (if8.done) begin idx = i; break; end
            @(posedge clk); #1;
        end
        checks++; if (idx !== 1) begin errors++; $display("FAIL d8_latency got %0d exp 1", idx); end
        checks++; if (if8.sum !== EXP_D8_SUM) begin errors++; $display("FAIL d8_sum got %h exp %h", if8.sum, EXP_D8_SUM); end
        checks++; if (if8.ovf !== 1'b1 || if8.cout !== 1'b0) begin
            errors++; $display("FAIL d8_flags got ovf %b cout %b exp 1 0", if8.ovf, if8.cout); end
        repeat (2) begin @(posedge clk); #1; end
        checks++; if (if8.sum !== EXP_D8_SUM || if8.done !== 1'b0) begin
            errors++; $display("FAIL d8_hold got sum %h done %b exp %h 0", if8.sum, if8.done, EXP_D8_SUM); end
    endtask

    initial begin
        rst_n = 1'b0;
        if1.start = 1'b0; if1.sub = 1'b0; if1.a = '0; if1.b = '0;
        if4.start = 1'b0; if4.sub = 1'b0; if4.a = '0; if4.b = '0;
        if8.start = 1'b0; if8.sub = 1'b0; if8.a = '0; if8.b = '0;
        test_reset;
        test_add_basic;
        test_back_to_back;
        test_start_ignored;
        test_reset_mid_run;
        test_digit4;
        test_digit8;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
